// File: rtl/psum_deskew_acc_if.sv
// Bundle of the data/handshake signals between the systolic row chains,
// the deskew/accumulate stage and the writeback consumer.
interface psum_deskew_acc_if #(
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_BW         = 32
);

  logic [MATRIX_SIZE*PARTIAL_SUM_BW-1:0] ROW_RESULTS;
  logic                                  in_valid;
  logic                                  in_first;
  logic                                  in_last;
  logic [MATRIX_SIZE*ACC_BW-1:0]         ACC_OUT;
  logic                                  out_valid;
  logic                                  out_ready;
  logic                                  busy;
  logic                                  overflow_err;
  logic                                  proto_err;

  // Producer/consumer side: drives row results and ready, observes results.
  modport master (
    output ROW_RESULTS, in_valid, in_first, in_last, out_ready,
    input  ACC_OUT, out_valid, busy, overflow_err, proto_err
  );

  // Deskew/accumulate block side.
  modport slave (
    input  ROW_RESULTS, in_valid, in_first, in_last, out_ready,
    output ACC_OUT, out_valid, busy, overflow_err, proto_err
  );

endinterface

// File: rtl/psum_deskew_acc.sv
// psum_deskew_acc: realigns the staggered per-row partial sums coming out of
// the systolic array, accumulates the aligned vectors across K-tiles and
// presents each finished output row to writeback over valid/ready.
module psum_deskew_acc #(
  parameter int PARTIAL_SUM_BW = 20,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_BW         = 32
) (
  input  logic             clk,
  input  logic             rstn,
  psum_deskew_acc_if.slave bus
);

  localparam int N  = MATRIX_SIZE;
  localparam int PW = PARTIAL_SUM_BW;
  localparam int D  = MATRIX_SIZE - 1;  // skew of row 0 = control delay

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  logic [N-1:0][PW-1:0]     aligned;
  logic [D-1:0]             vld_q, first_q, last_q;
  logic                     d_valid, d_first, d_last;
  logic [0:0]               state_q, state_d;
  logic [N-1:0][ACC_BW-1:0] acc_q, sum;
  logic [N*ACC_BW-1:0]      acc_out_q;
  logic                     out_valid_q, out_valid_d, load_out;
  logic                     overflow_q, overflow_d, proto_q, proto_d;
  logic                     restart;

  // Per-row delay lines: row i waits N-1-i cycles so all rows line up with
  // the last row, which arrives last and is used undelayed.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    localparam int DEPTH = N - 1 - gi;
    logic [PW-1:0] row_in;
    assign row_in = bus.ROW_RESULTS[(N-gi-1)*PW +: PW];

    if (DEPTH == 0) begin : g_direct
      assign aligned[gi] = row_in;
    end else begin : g_delay
      logic [PW-1:0] sr_q [DEPTH];

      // Shift the row result one stage per cycle.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          // NOTE: these delay lines are plain registers, not RAM, so they are
          // cleared on reset; an in-flight vector must not reappear later.
          for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
        end else begin
          sr_q[0] <= row_in;
          for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
        end
      end

      assign aligned[gi] = sr_q[DEPTH-1];
    end
  end

  // Carry valid/first/last alongside row 0 so they emerge with the aligned vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value of
      // the previous stage from before this edge, giving a true shift.
      vld_q[0]   <= bus.in_valid;
      first_q[0] <= bus.in_first;
      last_q[0]  <= bus.in_last;
      for (int k = 1; k < D; k++) begin
        vld_q[k]   <= vld_q[k-1];
        first_q[k] <= first_q[k-1];
        last_q[k]  <= last_q[k-1];
      end
    end
  end

  assign d_valid = vld_q[D-1];
  assign d_first = first_q[D-1];
  assign d_last  = last_q[D-1];

  // Per-lane sum: sign-extend each row result and add with two's-complement wrap.
  // A vector without first while idle starts a fresh sum as well.
  always_comb begin
    restart = d_first || (state_q == ST_IDLE);
    for (int i = 0; i < N; i++) begin
      sum[i] = (restart ? '0 : acc_q[i]) + ACC_BW'(signed'(aligned[i]));
    end
  end

  // Next state, output handshake and sticky error detection.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d     = state_q;
    out_valid_d = out_valid_q;
    overflow_d  = overflow_q;
    proto_d     = proto_q;
    load_out    = 1'b0;

    if (d_valid) begin
      if ((state_q == ST_IDLE) && !d_first) proto_d = 1'b1;
      if ((state_q == ST_ACCUM) && d_first && !d_last) proto_d = 1'b1;
      state_d = d_last ? ST_IDLE : ST_ACCUM;
    end

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (d_valid && d_last) begin
      if (!out_valid_q || bus.out_ready) begin
        load_out    = 1'b1;
        out_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Register accumulators, output row, FSM state and flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q       <= '0;
      acc_out_q   <= '0;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      proto_q     <= 1'b0;
    end else begin
      if (d_valid) acc_q <= sum;
      if (load_out) begin
        for (int i = 0; i < N; i++) acc_out_q[(N-1-i)*ACC_BW +: ACC_BW] <= sum[i];
      end
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      proto_q     <= proto_d;
    end
  end

  assign bus.ACC_OUT      = acc_out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = (|vld_q) || (state_q == ST_ACCUM);
  assign bus.overflow_err = overflow_q;
  assign bus.proto_err    = proto_q;

endmodule

// File: tb/tb_psum_deskew_acc.sv
// Bench for psum_deskew_acc: a transaction-level reference model (queue of
// issued vectors, per-lane integer sums) is compared against the DUT every
// cycle, plus a table of multi-tile accumulations and hand-written sequences
// for timing, back-pressure, protocol errors and mid-operation reset.
module tb_psum_deskew_acc;

  localparam int PSW  = 20;
  localparam int N    = 8;
  localparam int ABW  = 32;
  localparam int HIST = 16;

  typedef logic signed [PSW-1:0] lane_t;
  typedef logic signed [ABW-1:0] acc_t;
  typedef lane_t lanes_t [N];
  typedef acc_t  accs_t [N];
  typedef int    ivec_t [N];
  typedef logic [N*ABW-1:0] wide_t;

  typedef struct {
    int     t;
    bit     first;
    bit     last;
    lanes_t lanes;
  } vec_t;

  typedef struct {
    int ntiles;
    int tile_val [4];
    int exp_val;
  } tbl_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  psum_deskew_acc_if #(.PARTIAL_SUM_BW(PSW), .MATRIX_SIZE(N), .ACC_BW(ABW)) bus ();

  psum_deskew_acc #(.PARTIAL_SUM_BW(PSW), .MATRIX_SIZE(N), .ACC_BW(ABW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  lane_t  hist [HIST][N];
  vec_t   pend [$];
  bit     m_open, m_valid, m_ovf, m_proto;
  accs_t  m_acc;
  accs_t  m_out;
  tbl_t   tbl [6];

  task automatic check(input string name, input wide_t act, input wide_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %b, want %b", name, cyc, act, exp);
    end
  endtask

  function automatic wide_t pack_acc(input accs_t v);
    wide_t r;
    r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*ABW +: ABW] = v[i];
    return r;
  endfunction

  function automatic wide_t pack_int(input ivec_t v);
    wide_t r;
    r = '0;
    for (int i = 0; i < N; i++) r[(N-1-i)*ABW +: ABW] = acc_t'(v[i]);
    return r;
  endfunction

  function automatic ivec_t ivec_all(input int v);
    ivec_t r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  function automatic lanes_t fill(input int v);
    lanes_t r;
    for (int i = 0; i < N; i++) r[i] = lane_t'(v);
    return r;
  endfunction

  function automatic tbl_t mk_tbl(input int n, input int a, input int b,
                                  input int c, input int d, input int e);
    tbl_t r;
    r.ntiles      = n;
    r.tile_val[0] = a;
    r.tile_val[1] = b;
    r.tile_val[2] = c;
    r.tile_val[3] = d;
    r.exp_val     = e;
    return r;
  endfunction

  task automatic model_reset();
    m_open  = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_proto = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_acc[i] = '0;
      m_out[i] = '0;
    end
    pend.delete();
  endtask

  // Reference behaviour at one clock edge: a vector issued at cycle t takes
  // effect at the edge ending cycle t+N-1.
  task automatic model_edge(input bit rdy);
    bit   accept;
    bit   load;
    bit   fresh;
    vec_t x;
    accept = m_valid && rdy;
    load   = 1'b0;
    if (pend.size() > 0 && pend[0].t == cyc - (N - 1)) begin
      x = pend.pop_front();
      if (!m_open && !x.first) m_proto = 1'b1;
      if (m_open && x.first && !x.last) m_proto = 1'b1;
      fresh = x.first || !m_open;
      for (int i = 0; i < N; i++) begin
        m_acc[i] = (fresh ? acc_t'(0) : m_acc[i]) + acc_t'(x.lanes[i]);
      end
      m_open = !x.last;
      if (x.last) begin
        if (!m_valid || accept) begin
          load  = 1'b1;
          m_out = m_acc;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (load) m_valid = 1'b1;
    else if (accept) m_valid = 1'b0;
  endtask

  task automatic check_model();
    check_bit("out_valid", bus.out_valid, m_valid);
    check_bit("busy", bus.busy, (pend.size() > 0) || m_open);
    check_bit("overflow_err", bus.overflow_err, m_ovf);
    check_bit("proto_err", bus.proto_err, m_proto);
    check("ACC_OUT", bus.ACC_OUT, pack_acc(m_out));
  endtask

  // One clock cycle, entered and left at the falling edge. Row i shows the
  // lane of the vector issued i cycles earlier (random filler otherwise).
  task automatic cycle(input bit v, input bit f, input bit l, input bit rdy,
                       input lanes_t lanes);
    vec_t              x;
    logic [N*PSW-1:0]  rr;
    int                slot;
    check_model();
    slot = cyc % HIST;
    for (int i = 0; i < N; i++) hist[slot][i] = v ? lanes[i] : lane_t'($urandom());
    if (v) begin
      x.t     = cyc;
      x.first = f;
      x.last  = l;
      x.lanes = lanes;
      pend.push_back(x);
    end
    for (int i = 0; i < N; i++) rr[(N-1-i)*PSW +: PSW] = hist[(cyc + HIST - i) % HIST][i];
    bus.ROW_RESULTS = rr;
    bus.in_valid    = v;
    bus.in_first    = f;
    bus.in_last     = l;
    bus.out_ready   = rdy;
    @(posedge clk);
    model_edge(rdy);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, rdy, fill(0));
  endtask

  // Assert reset mid-cycle, check outputs clear without a clock edge, hold
  // for two edges and release on a falling edge.
  task automatic async_reset(input string tag);
    #2 rstn = 1'b0;
    #1;
    check_bit({tag, " out_valid"}, bus.out_valid, 1'b0);
    check_bit({tag, " busy"}, bus.busy, 1'b0);
    check_bit({tag, " overflow_err"}, bus.overflow_err, 1'b0);
    check_bit({tag, " proto_err"}, bus.proto_err, 1'b0);
    check({tag, " ACC_OUT"}, bus.ACC_OUT, '0);
    model_reset();
    bus.in_valid  = 1'b0;
    bus.in_first  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    for (int s = 0; s < HIST; s++)
      for (int i = 0; i < N; i++) hist[s][i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc += 2;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t la, lx, ly, lz;
    ivec_t  iv, ix, iz;
    bit     v, f, l, rdy;

    tbl[0] = mk_tbl(3, -5, 100, 7, 0, 102);
    tbl[1] = mk_tbl(1, 524287, 0, 0, 0, 524287);
    tbl[2] = mk_tbl(2, 524287, 524287, 0, 0, 1048574);
    tbl[3] = mk_tbl(4, -1, -1, -1, -1, -4);
    tbl[4] = mk_tbl(2, -524288, 524287, 0, 0, -1);
    tbl[5] = mk_tbl(4, 300000, -100000, 50, -7, 200043);

    bus.ROW_RESULTS = '0;
    bus.in_valid    = 1'b0;
    bus.in_first    = 1'b0;
    bus.in_last     = 1'b0;
    bus.out_ready   = 1'b0;

    @(negedge clk);
    async_reset("reset");
    idle(2, 1'b1);

    // Single tile, row i = i+1: result visible exactly N cycles later, one cycle wide.
    for (int i = 0; i < N; i++) begin
      la[i] = lane_t'(i + 1);
      iv[i] = i + 1;
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, la);
    idle(6, 1'b1);
    check_bit("single +7 out_valid", bus.out_valid, 1'b0);
    idle(1, 1'b1);
    check_bit("single +8 out_valid", bus.out_valid, 1'b1);
    check("single +8 ACC_OUT", bus.ACC_OUT, pack_int(iv));
    idle(1, 1'b1);
    check_bit("single +9 out_valid", bus.out_valid, 1'b0);
    idle(2, 1'b1);

    // Back-to-back multi-tile accumulations from the table.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < tbl[r].ntiles; k++) begin
        cycle(1'b1, k == 0, k == tbl[r].ntiles - 1, 1'b1, fill(tbl[r].tile_val[k]));
      end
      idle(N - 2, 1'b1);
      check_bit($sformatf("tbl%0d busy before", r), bus.busy, 1'b1);
      idle(1, 1'b1);
      check_bit($sformatf("tbl%0d out_valid", r), bus.out_valid, 1'b1);
      check($sformatf("tbl%0d ACC_OUT", r), bus.ACC_OUT, pack_int(ivec_all(tbl[r].exp_val)));
      check_bit($sformatf("tbl%0d busy after", r), bus.busy, 1'b0);
      idle(2, 1'b1);
    end
    check_bit("tbl overflow_err", bus.overflow_err, 1'b0);
    check_bit("tbl proto_err", bus.proto_err, 1'b0);

    // Most negative row value over 16 tiles: sign extension into 32 bits.
    for (int k = 0; k < 16; k++) cycle(1'b1, k == 0, k == 15, 1'b1, fill(-524288));
    idle(7, 1'b1);
    check_bit("minval out_valid", bus.out_valid, 1'b1);
    check("minval ACC_OUT", bus.ACC_OUT, pack_int(ivec_all(-8388608)));
    idle(3, 1'b1);

    // Back-pressure: hold X, accept-and-load Z on the same edge, drop Y.
    for (int i = 0; i < N; i++) begin
      lx[i] = lane_t'(i * 7 - 20);
      ix[i] = i * 7 - 20;
      lz[i] = lane_t'(-(i + 1) * 1000);
      iz[i] = -(i + 1) * 1000;
    end
    ly = fill(12345);
    for (int k = 0; k <= 44; k++) begin
      if (k >= 8 && k <= 27) begin
        check_bit($sformatf("hold%0d out_valid", k), bus.out_valid, 1'b1);
        check($sformatf("hold%0d ACC_OUT", k), bus.ACC_OUT, pack_int(ix));
      end
      if (k == 29) begin
        check("swap ACC_OUT", bus.ACC_OUT, pack_int(iz));
        check_bit("swap out_valid", bus.out_valid, 1'b1);
        check_bit("swap overflow_err", bus.overflow_err, 1'b0);
      end
      if (k == 40) begin
        check_bit("drop overflow_err", bus.overflow_err, 1'b1);
        check("drop ACC_OUT", bus.ACC_OUT, pack_int(iz));
      end
      if (k == 44) check_bit("drain out_valid", bus.out_valid, 1'b0);
      rdy = (k == 28) || (k >= 42);
      if (k == 0)       cycle(1'b1, 1'b1, 1'b1, rdy, lx);
      else if (k == 21) cycle(1'b1, 1'b1, 1'b1, rdy, lz);
      else if (k == 30) cycle(1'b1, 1'b1, 1'b1, rdy, ly);
      else              cycle(1'b0, 1'b0, 1'b0, rdy, fill(0));
    end

    // Protocol: no first while idle, then first while accumulating.
    check_bit("pre-proto proto_err", bus.proto_err, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, fill(3));
    cycle(1'b1, 1'b0, 1'b0, 1'b0, fill(4));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, fill(50));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, fill(6));
    idle(7, 1'b0);
    check_bit("proto proto_err", bus.proto_err, 1'b1);
    check_bit("proto out_valid", bus.out_valid, 1'b1);
    check("proto ACC_OUT", bus.ACC_OUT, pack_int(ivec_all(56)));

    // Reset two cycles after a last vector is issued, result still held.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, fill(777));
    idle(1, 1'b0);
    check_bit("pre-reset busy", bus.busy, 1'b1);
    async_reset("midreset");
    idle(12, 1'b1);
    check_bit("post-reset out_valid", bus.out_valid, 1'b0);
    for (int i = 0; i < N; i++) begin
      la[i] = lane_t'(i * 1000 - 3000);
      iv[i] = i * 1000 - 3000;
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1, la);
    idle(7, 1'b1);
    check_bit("clean out_valid", bus.out_valid, 1'b1);
    check("clean ACC_OUT", bus.ACC_OUT, pack_int(iv));
    idle(2, 1'b1);

    // Random traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      v   = ($urandom() % 2) == 0;
      f   = ($urandom() % 3) == 0;
      l   = ($urandom() % 3) == 0;
      rdy = ($urandom() % 4) != 0;
      for (int i = 0; i < N; i++) la[i] = lane_t'($urandom());
      cycle(v, f, l, rdy, la);
    end
    idle(12, 1'b1);
    check_model();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_deskew_acc.md
Name: psum_deskew_acc

Overview:
- Downstream stage of the systolic array. Collects the per-row partial-sum results from the MATRIX_SIZE row chains.
- Row i's result emerges one cycle later than row i-1. This block deskews the rows into one aligned vector.
- It accumulates aligned vectors across K-tiles into ACC_BW-wide accumulators. It then presents the finished output row on a valid/ready interface to the writeback logic.

Parameters:
- PARTIAL_SUM_BW, 20, width of each row result (signed).
- MATRIX_SIZE, 8, number of array rows (vector lanes).
- ACC_BW, 32, width of each accumulator lane (signed, ACC_BW >= PARTIAL_SUM_BW).

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- ROW_RESULTS  input  MATRIX_SIZE*PARTIAL_SUM_BW  row results, signed. Row i occupies slice [(MATRIX_SIZE-i-1)*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], so row 0 is in the MSBs.
- in_valid  input  1  row 0 result valid this cycle; row i is valid i cycles later.
- in_first  input  1  qualified by in_valid; this vector starts a new accumulation.
- in_last  input  1  qualified by in_valid; this vector ends the accumulation.
- ACC_OUT  output  MATRIX_SIZE*ACC_BW  finished accumulations, same lane ordering as ROW_RESULTS.
- out_valid  output  1  ACC_OUT holds an unconsumed result.
- out_ready  input  1  consumer accepts ACC_OUT when out_valid && out_ready.
- busy  output  1  skew pipeline non-empty or accumulation open.
- overflow_err  output  1  sticky; a finished result was dropped.
- proto_err  output  1  sticky; protocol violation detected.

Behaviour:
- Reset: asynchronous, active-low. All delay registers, accumulators and ACC_OUT go to 0. out_valid, busy, overflow_err and proto_err go to 0. State goes to IDLE. An in-flight vector is discarded with no output.
- Deskew: row i is delayed by MATRIX_SIZE-1-i registers; row MATRIX_SIZE-1 is undelayed.
  - For in_valid at cycle t, the aligned vector is complete at cycle t+MATRIX_SIZE-1.
  - in_valid, in_first and in_last travel through a MATRIX_SIZE-1 stage shift register alongside it.
  - A new in_valid is allowed every cycle; the pipeline is fully pipelined with no stalls. The upstream array cannot be back-pressured.
- Arithmetic: each lane is sign-extended to ACC_BW and added with two's-complement wrap. There is no saturation.
- Accumulator update occurs on the edge ending cycle t+MATRIX_SIZE-1 when the delayed valid is set:
  - acc <= (first ? 0 : acc) + aligned.
- State machine:
  - IDLE: delayed valid with first moves to ACCUM, or stays in IDLE if last is also set. Delayed valid without first is treated as first and sets proto_err.
  - ACCUM: delayed valid with last moves to IDLE. Delayed valid with first (and not last) restarts the sum from zero, stays in ACCUM and sets proto_err.
- Output load: when the delayed vector has last set, ACC_OUT is loaded with the final sum and out_valid=1 from cycle t+MATRIX_SIZE. Accumulation latency is MATRIX_SIZE cycles from in_valid of the last vector.
- Handshake:
  - out_valid clears on the edge where out_valid && out_ready, unless a new result loads on that same edge. A simultaneous accept and load makes the new result valid, and no error is raised.
  - If a new result arrives while out_valid=1 and out_ready=0: ACC_OUT and out_valid keep the old result, the new result is dropped, and overflow_err is set.
  - ACC_OUT is stable while out_valid && !out_ready.
- busy = any delayed valid set || state==ACCUM.
- Sticky flags clear only on reset.

Test Plan:
- Single tile, MATRIX_SIZE=8: in_valid/first/last in one cycle at t=10, row i value = i+1, each row presented at t=10+i.
  - Required: out_valid rises at t=18 and ACC_OUT lanes = 1..8 (row 0 in the MSBs).
  - out_ready held high: out_valid stays high exactly one cycle.
- Three-tile accumulation on back-to-back cycles t=0,1,2 (first, mid, last), all rows = -5, 100, 7.
  - Required: every lane = 102 at t=2+8.
  - Required: no error flags set and busy deasserts at t=10.
- Back-pressure: result held with out_ready=0 for 20 cycles.
  - Required: ACC_OUT stable and out_valid high.
  - A second last arriving during the hold sets overflow_err and leaves the first result unchanged.
  - A last arriving on the cycle out_ready rises is loaded cleanly with no error.
- Sign/width: rows = -524288 (min 20-bit), 16 tiles.
  - Required: lanes = -8388608, correctly sign-extended to 32 bits.
- Protocol: in_valid without first while IDLE, then first while ACCUM.
  - Required: proto_err=1 and the sums restart from that vector.
- Reset mid-operation: rstn low 2 cycles after in_valid of a last vector.
  - Required: all outputs 0 immediately (asynchronous) and no out_valid afterwards.
  - A subsequent clean single tile produces the correct result.
